// File: rtl/debruijn_monitor.sv
// Checks a 4-bit de Bruijn generator stream: shift continuity plus exactly-once code coverage per period.
// Latency: all outputs registered, visible the cycle after the sampled state is clocked in.
// Backpressure: none; samples every clock while run=1, run=0 abandons the current period.
module debruijn_monitor (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  state,
    input  logic        run,
    input  logic        clr,
    output logic [15:0] seen,
    output logic [4:0]  count,
    output logic        period_ok,
    output logic [7:0]  periods,
    output logic        err,
    output logic [1:0]  err_code
);

    typedef enum logic [1:0] {IDLE, TRACK, FAULT} fsm_t;

    localparam logic [1:0] CAUSE_NONE  = 2'b00;
    localparam logic [1:0] CAUSE_SHIFT = 2'b01;
    localparam logic [1:0] CAUSE_DUP   = 2'b10;
    localparam logic [1:0] CAUSE_WRAP  = 2'b11;

    fsm_t        fsm, fsm_n;
    logic [3:0]  start, start_n;
    logic [3:0]  prev, prev_n;
    logic [15:0] seen_n;
    logic [4:0]  count_n;
    logic        period_ok_n;
    logic [7:0]  periods_n;
    logic        err_n;
    logic [1:0]  err_code_n;
    logic [1:0]  cause;
    logic [15:0] onehot;

    assign onehot = 16'd1 << state;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fsm       <= IDLE;
            start     <= '0;
            prev      <= '0;
            seen      <= '0;
            count     <= '0;
            period_ok <= 1'b0;
            periods   <= '0;
            err       <= 1'b0;
            err_code  <= CAUSE_NONE;
        end else begin
            fsm       <= fsm_n;
            start     <= start_n;
            prev      <= prev_n;
            seen      <= seen_n;
            count     <= count_n;
            period_ok <= period_ok_n;
            periods   <= periods_n;
            err       <= err_n;
            err_code  <= err_code_n;
        end
    end

    always_comb begin
        fsm_n       = fsm;
        start_n     = start;
        prev_n      = prev;
        seen_n      = seen;
        count_n     = count;
        period_ok_n = 1'b0;
        periods_n   = periods;
        err_n       = err;
        err_code_n  = err_code;
        cause       = CAUSE_NONE;

        case (fsm)
            IDLE: begin
                if (run) begin
                    start_n = state;
                    prev_n  = state;
                    seen_n  = onehot;
                    count_n = 5'd1;
                    fsm_n   = TRACK;
                end
            end
            TRACK: begin
                if (!run) begin
                    seen_n  = '0;
                    count_n = '0;
                    fsm_n   = IDLE;
                end else begin
                    prev_n = state;
                    // Check order fixes which cause is reported when several apply.
                    if (state[3:1] != prev[2:0]) begin
                        cause = CAUSE_SHIFT;
                    end else if (count == 5'd16 && state == start) begin
                        period_ok_n = 1'b1;
                        if (periods != 8'hFF) periods_n = periods + 8'd1;
                        seen_n  = onehot;
                        count_n = 5'd1;
                    end else if (count == 5'd16) begin
                        cause = CAUSE_WRAP;
                    end else if (seen[state]) begin
                        cause = CAUSE_DUP;
                    end else begin
                        seen_n  = seen | onehot;
                        count_n = count + 5'd1;
                    end
                    if (cause != CAUSE_NONE) fsm_n = FAULT;
                end
            end
            FAULT: begin
                if (!run) begin
                    seen_n  = '0;
                    count_n = '0;
                    fsm_n   = IDLE;
                end
            end
            default: fsm_n = IDLE;
        endcase

        if (clr) begin
            err_n      = 1'b0;
            err_code_n = CAUSE_NONE;
            periods_n  = '0;
        end
        // A fresh error beats a simultaneous clear; otherwise the first cause sticks.
        if (cause != CAUSE_NONE) begin
            err_n = 1'b1;
            if (!err || clr) err_code_n = cause;
        end
    end

endmodule

// File: tb/tb_debruijn_monitor.sv
// Scoreboarded bench for debruijn_monitor: expectations queued per driven sample, checked after the edge.
module tb_debruijn_monitor;

    logic        clk;
    logic        rst;
    logic [3:0]  state;
    logic        run;
    logic        clr;
    logic [15:0] seen;
    logic [4:0]  count;
    logic        period_ok;
    logic [7:0]  periods;
    logic        err;
    logic [1:0]  err_code;

    debruijn_monitor dut (
        .clk       (clk),
        .rst       (rst),
        .state     (state),
        .run       (run),
        .clr       (clr),
        .seen      (seen),
        .count     (count),
        .period_ok (period_ok),
        .periods   (periods),
        .err       (err),
        .err_code  (err_code)
    );

    typedef struct {
        string       tag;
        logic [4:0]  cnt;
        logic        pok;
        logic [7:0]  per;
        logic        er;
        logic [1:0]  code;
        bit          chk_seen;
        logic [15:0] seen;
    } exp_t;

    exp_t       sb[$];
    logic [3:0] seq [0:15];
    int         nchk;
    int         nfail;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
        nchk++;
        if (got !== want) begin
            nfail++;
            $display("FAIL %s got=%0h want=%0h", tag, got, want);
        end
    endtask

    function automatic exp_t mk(input string tag, input int cnt, input bit pok, input int per,
                                input bit er, input int code);
        exp_t e;
        e.tag      = tag;
        e.cnt      = cnt[4:0];
        e.pok      = pok;
        e.per      = per[7:0];
        e.er       = er;
        e.code     = code[1:0];
        e.chk_seen = 1'b0;
        e.seen     = '0;
        return e;
    endfunction

    // Drive one sample, queue its expected result, then check once the edge has landed.
    task automatic step(input logic r, input logic [3:0] s, input logic c, input exp_t e);
        exp_t g;
        run   = r;
        state = s;
        clr   = c;
        sb.push_back(e);
        @(posedge clk);
        #1;
        if (sb.size() == 0) begin
            chk("scoreboard_empty", 32'd0, 32'd1);
        end else begin
            g = sb.pop_front();
            chk({g.tag, ".count"},     32'(count),     32'(g.cnt));
            chk({g.tag, ".period_ok"}, 32'(period_ok), 32'(g.pok));
            chk({g.tag, ".periods"},   32'(periods),   32'(g.per));
            chk({g.tag, ".err"},       32'(err),       32'(g.er));
            chk({g.tag, ".err_code"},  32'(err_code),  32'(g.code));
            if (g.chk_seen) chk({g.tag, ".seen"}, 32'(seen), 32'(g.seen));
        end
    endtask

    initial begin
        automatic exp_t e;
        nchk  = 0;
        nfail = 0;
        seq   = '{4'd1, 4'd2, 4'd4, 4'd9, 4'd3, 4'd6, 4'd13, 4'd10,
                  4'd5, 4'd11, 4'd7, 4'd15, 4'd14, 4'd12, 4'd8, 4'd0};
        run   = 1'b0;
        clr   = 1'b0;
        state = 4'd0;
        rst   = 1'b1;
        #2 rst = 1'b0;
        #5;
        chk("rst.seen",      32'(seen),      32'd0);
        chk("rst.count",     32'(count),     32'd0);
        chk("rst.period_ok", 32'(period_ok), 32'd0);
        chk("rst.periods",   32'(periods),   32'd0);
        chk("rst.err",       32'(err),       32'd0);
        chk("rst.err_code",  32'(err_code),  32'd0);
        @(negedge clk);
        rst = 1'b1;

        // Reset asserted mid-period at count 7.
        for (int i = 0; i < 7; i++) step(1'b1, seq[i], 1'b0, mk("pre", i + 1, 1'b0, 0, 1'b0, 0));
        #2 rst = 1'b0;
        #1;
        chk("arst.seen",      32'(seen),      32'd0);
        chk("arst.count",     32'(count),     32'd0);
        chk("arst.periods",   32'(periods),   32'd0);
        chk("arst.err",       32'(err),       32'd0);
        chk("arst.period_ok", 32'(period_ok), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            e = mk("idle_hold", 0, 1'b0, 0, 1'b0, 0);
            e.chk_seen = 1'b1;
            e.seen     = 16'h0000;
            step(1'b0, seq[i], 1'b0, e);
        end

        // Three back-to-back good periods plus the closing sample.
        for (int i = 0; i < 49; i++) begin
            e = mk("good", i % 16 + 1, (i > 0 && i % 16 == 0), i / 16, 1'b0, 0);
            if (i % 16 == 15) begin
                e.chk_seen = 1'b1;
                e.seen     = 16'hFFFF;
            end else if (i % 16 == 0) begin
                e.chk_seen = 1'b1;
                e.seen     = 16'h0002;
            end
            step(1'b1, seq[i % 16], 1'b0, e);
        end
        e = mk("stop", 0, 1'b0, 3, 1'b0, 0);
        e.chk_seen = 1'b1;
        e.seen     = 16'h0000;
        step(1'b0, 4'd0, 1'b0, e);

        // SHIFT break: 2 -> 7 is not a left shift.
        step(1'b1, 4'd1, 1'b0, mk("sh1", 1, 1'b0, 3, 1'b0, 0));
        step(1'b1, 4'd2, 1'b0, mk("sh2", 2, 1'b0, 3, 1'b0, 0));
        step(1'b1, 4'd7, 1'b0, mk("sh_err", 2, 1'b0, 3, 1'b1, 1));
        step(1'b1, 4'd4, 1'b0, mk("sh_fault", 2, 1'b0, 3, 1'b1, 1));
        step(1'b0, 4'd0, 1'b0, mk("sh_idle", 0, 1'b0, 3, 1'b1, 1));
        step(1'b0, 4'd0, 1'b1, mk("sh_clr", 0, 1'b0, 0, 1'b0, 0));

        // DUP, then a later SHIFT must not overwrite the first cause.
        step(1'b1, 4'd0,  1'b0, mk("dup1", 1, 1'b0, 0, 1'b0, 0));
        step(1'b1, 4'd0,  1'b0, mk("dup_err", 1, 1'b0, 0, 1'b1, 2));
        step(1'b1, 4'd15, 1'b0, mk("dup_fault", 1, 1'b0, 0, 1'b1, 2));
        step(1'b0, 4'd0,  1'b0, mk("dup_idle", 0, 1'b0, 0, 1'b1, 2));
        step(1'b1, 4'd1,  1'b0, mk("dup_re", 1, 1'b0, 0, 1'b1, 2));
        step(1'b1, 4'd8,  1'b0, mk("dup_sh", 1, 1'b0, 0, 1'b1, 2));
        step(1'b0, 4'd0,  1'b1, mk("dup_clr", 0, 1'b0, 0, 1'b0, 0));

        // Reseed: partial period, one idle cycle, then a full period starting at 8.
        for (int i = 0; i < 9; i++) step(1'b1, seq[i], 1'b0, mk("rs_a", i + 1, 1'b0, 0, 1'b0, 0));
        step(1'b0, 4'd0, 1'b0, mk("rs_gap", 0, 1'b0, 0, 1'b0, 0));
        for (int j = 0; j < 17; j++)
            step(1'b1, seq[(14 + j) % 16], 1'b0,
                 mk("rs_b", j % 16 + 1, (j == 16), (j == 16) ? 1 : 0, 1'b0, 0));
        step(1'b0, 4'd0, 1'b1, mk("sat_pre", 0, 1'b0, 0, 1'b0, 0));

        // 260 good periods saturate the counter at 255.
        for (int i = 0; i < 4176; i++)
            step(1'b1, seq[i % 16], 1'b0,
                 mk("sat", i % 16 + 1, (i > 0 && i % 16 == 0), (i / 16 > 255) ? 255 : i / 16, 1'b0, 0));
        // Wrong code at count 16 with clr on the same edge: error wins, periods still cleared.
        step(1'b1, 4'd0, 1'b1, mk("wrap_clr", 16, 1'b0, 0, 1'b1, 3));
        step(1'b1, 4'd1, 1'b0, mk("wrap_hold", 16, 1'b0, 0, 1'b1, 3));

        $display("TB_RESULT checks=%0d failures=%0d", nchk, nfail);
        $finish;
    end

endmodule
